// File: rtl/sequential_arith_unit.sv
// sequential_arith_unit
//
// Multi-cycle arithmetic unit with two operand registers (A, B) loaded from a
// shared data bus. Supports add, subtract, accumulate (add and write the sum
// back into A) and, optionally, an unsigned shift-add multiply.
//
// Configuration macro: ARITH_MUL_EN
//   defined   -> MUL state and shift-add datapath are built; Op=10 multiplies
//   undefined -> Op=10 is illegal: it takes the EXEC path timing and leaves
//                Result, ResultHi and Flags untouched; no multiplier logic
//
// Ports
//   Clock    : single clock, rising edge
//   Clear    : synchronous active-high reset, highest priority
//   X        : shared operand data bus (WIDTH bits)
//   LoadA    : load X into A (only in IDLE with Start low)
//   LoadB    : load X into B (only in IDLE with Start low)
//   Op       : 00 add, 01 subtract, 10 multiply, 11 accumulate
//   Start    : one-cycle request, honoured only in IDLE
//   Result   : registered low result
//   ResultHi : registered upper product half (zero for non-multiply ops)
//   Flags    : registered {N,Z,C,V}
//   Busy     : high while in EXEC or MUL
//   Done     : one-cycle completion pulse
//
// Timing: with Start sampled at edge 0, add/sub/acc raise Done after edge 2
// and multiply raises Done after edge WIDTH+2. Done is registered off the
// DONE state, so it appears in the cycle following DONE.

module sequential_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [WIDTH-1:0] X,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic [1:0]       Op,
    input  logic             Start,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic [3:0]       Flags,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } stateT;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    stateT            state;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [1:0]       opLatched;

`ifdef ARITH_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] prodAcc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      mulCount;
    logic [3:0]         mulFlags;
`endif

    logic [WIDTH-1:0] bEff;
    logic             carryIn;
    logic [WIDTH:0]   sumFull;
    logic [WIDTH-1:0] sumLow;
    logic             overflow;
    logic [3:0]       addFlags;

    // Single ripple adder shared by add, subtract and accumulate. Subtract is
    // A + ~B + 1, so the carry out means "no borrow" and the overflow rule is
    // the same as for add once B has been conditionally inverted.
    always_comb begin
        bEff     = (opLatched == OP_SUB) ? ~opB : opB;
        carryIn  = (opLatched == OP_SUB);
        sumFull  = {1'b0, opA} + {1'b0, bEff} + {{WIDTH{1'b0}}, carryIn};
        sumLow   = sumFull[WIDTH-1:0];
        overflow = (opA[WIDTH-1] == bEff[WIDTH-1]) && (sumLow[WIDTH-1] != opA[WIDTH-1]);
        addFlags = {sumLow[WIDTH-1], (sumLow == '0), sumFull[WIDTH], overflow};
    end

`ifdef ARITH_MUL_EN
    // Product flags: N is the product MSB, C is always clear and V reports a
    // product that does not fit in the low half.
    always_comb begin
        mulFlags = {prodAcc[2*WIDTH-1], (prodAcc == '0), 1'b0,
                    (prodAcc[2*WIDTH-1:WIDTH] != '0)};
    end
`endif

    // Main controller. Operands are copied into opA/opB on Start so the
    // operand registers can never disturb an operation in flight; loads are
    // only honoured in IDLE when no Start is present. Clear wins over
    // everything and also swallows any pending Done.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state     <= IDLE;
            regA      <= '0;
            regB      <= '0;
            opA       <= '0;
            opB       <= '0;
            opLatched <= OP_ADD;
            Result    <= '0;
            ResultHi  <= '0;
            Flags     <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef ARITH_MUL_EN
            prodAcc   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mulCount  <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        opLatched <= Op;
                        opA       <= regA;
                        opB       <= regB;
                        Busy      <= 1'b1;
`ifdef ARITH_MUL_EN
                        if (Op == OP_MUL) begin
                            prodAcc  <= '0;
                            mcand    <= {{WIDTH{1'b0}}, regA};
                            mplier   <= regB;
                            mulCount <= '0;
                            state    <= MUL;
                        end else begin
                            state <= EXEC;
                        end
`else
                        state <= EXEC;
`endif
                    end else begin
                        if (LoadA) regA <= X;
                        if (LoadB) regB <= X;
                    end
                end

                EXEC: begin
                    // Op=10 only reaches EXEC when the multiplier is not
                    // built; it then completes without touching the outputs.
                    if (opLatched != OP_MUL) begin
                        Result   <= sumLow;
                        ResultHi <= '0;
                        Flags    <= addFlags;
                        if (opLatched == OP_ACC) regA <= sumLow;
                    end
                    Busy  <= 1'b0;
                    state <= DONE;
                end

`ifdef ARITH_MUL_EN
                MUL: begin
                    // WIDTH partial-product cycles, then one cycle that
                    // publishes the finished product.
                    if (mulCount == CW'(WIDTH)) begin
                        Result   <= prodAcc[WIDTH-1:0];
                        ResultHi <= prodAcc[2*WIDTH-1:WIDTH];
                        Flags    <= mulFlags;
                        Busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        if (mplier[0]) prodAcc <= prodAcc + mcand;
                        mcand    <= mcand << 1;
                        mplier   <= mplier >> 1;
                        mulCount <= mulCount + 1'b1;
                    end
                end
`endif

                DONE: begin
                    Done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_arith_unit.sv
// tb_sequential_arith_unit
//
// Directed bench for sequential_arith_unit (WIDTH=8). Each operation pushes
// its hand-computed response into a queue; a monitor pops and compares
// whenever Done is seen. Latency, Busy length and abort behaviour are checked
// by the stimulus tasks. Multiply vectors are used when ARITH_MUL_EN is
// defined, the illegal-Op vector otherwise.

module tb_sequential_arith_unit;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [7:0] resHi;
        logic [3:0] flags;
    } expT;

    logic       clock;
    logic       clear;
    logic [7:0] x;
    logic       loadA;
    logic       loadB;
    logic [1:0] op;
    logic       start;
    logic [7:0] result;
    logic [7:0] resultHi;
    logic [3:0] flags;
    logic       busy;
    logic       done;

    expT expQ[$];
    int  checks;
    int  errors;
    int  doneCount;

    sequential_arith_unit #(.WIDTH(8)) dut (
        .Clock    (clock),
        .Clear    (clear),
        .X        (x),
        .LoadA    (loadA),
        .LoadB    (loadB),
        .Op       (op),
        .Start    (start),
        .Result   (result),
        .ResultHi (resultHi),
        .Flags    (flags),
        .Busy     (busy),
        .Done     (done)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point shared by all checks
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every Done pulse must match the oldest expectation
    initial begin
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got Done=1 expected no pulse");
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    checkOutput({e.name, "_result"},   32'(result),   32'(e.res));
                    checkOutput({e.name, "_resultHi"}, 32'(resultHi), 32'(e.resHi));
                    checkOutput({e.name, "_flags"},    32'(flags),    32'(e.flags));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic loadOperands(input logic [7:0] a, input logic [7:0] b);
        x = a; loadA = 1'b1;
        tick();
        loadA = 1'b0;
        x = b; loadB = 1'b1;
        tick();
        loadB = 1'b0;
    endtask

    // Issues one operation and waits (bounded) for Done. With disturb set, a
    // LoadA of AA and a second Start are driven during the first busy cycle.
    task automatic applyStimulus(input string name, input logic [1:0] opSel,
                                 input logic [7:0] expRes, input logic [7:0] expHi,
                                 input logic [3:0] expFlags, input int expLatency,
                                 input int expBusy, input bit disturb);
        expT e;
        int  n;
        int  busyCycles;
        bit  seen;
        e.name = name; e.res = expRes; e.resHi = expHi; e.flags = expFlags;
        expQ.push_back(e);
        op    = opSel;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; busyCycles = 0; seen = 1'b0;
        if (busy) busyCycles++;
        if (disturb) begin
            x = 8'hAA; loadA = 1'b1; start = 1'b1;
        end
        while (n < 40 && !seen) begin
            tick();
            n++;
            if (disturb && n == 1) begin
                loadA = 1'b0; start = 1'b0;
            end
            if (done) seen = 1'b1;
            else if (busy) busyCycles++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no Done expected Done within 40 cycles", name);
        end else begin
            checkOutput({name, "_latency"}, 32'(n), 32'(expLatency));
            checkOutput({name, "_busy"}, 32'(busyCycles), 32'(expBusy));
        end
        tick();
        checkOutput({name, "_done_width"}, 32'(done), 32'd0);
    endtask

    // Starts an operation, asserts Clear after abortAfter busy edges and
    // checks that nothing is published and the block is back in reset state.
    task automatic abortTest(input string name, input logic [1:0] opSel,
                             input int abortAfter);
        int doneBefore;
        op    = opSel;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (abortAfter) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        doneBefore = doneCount;
        checkOutput({name, "_busy"},   32'(busy),   32'd0);
        checkOutput({name, "_result"}, 32'(result), 32'd0);
        checkOutput({name, "_flags"},  32'(flags),  32'd0);
        repeat (14) tick();
        checkOutput({name, "_no_done"}, 32'(doneCount - doneBefore), 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; doneCount = 0;
        clear = 1'b1; x = '0; loadA = 1'b0; loadB = 1'b0; op = 2'b00; start = 1'b0;
        repeat (3) tick();
        clear = 1'b0;
        checkOutput("reset_result",   32'(result),   32'd0);
        checkOutput("reset_resultHi", 32'(resultHi), 32'd0);
        checkOutput("reset_flags",    32'(flags),    32'd0);
        checkOutput("reset_busy",     32'(busy),     32'd0);
        checkOutput("reset_done",     32'(done),     32'd0);

        loadOperands(8'h05, 8'h03);
        applyStimulus("add_05_03", 2'b00, 8'h08, 8'h00, 4'b0000, 2, 1, 1'b0);

`ifndef ARITH_MUL_EN
        // Illegal multiply: outputs keep the previous add result
        applyStimulus("illegal_mul", 2'b10, 8'h08, 8'h00, 4'b0000, 2, 1, 1'b0);
`endif

        loadOperands(8'h03, 8'h05);
        applyStimulus("sub_03_05", 2'b01, 8'hFE, 8'h00, 4'b1000, 2, 1, 1'b0);
        loadOperands(8'h7F, 8'h01);
        applyStimulus("add_7F_01", 2'b00, 8'h80, 8'h00, 4'b1001, 2, 1, 1'b0);
        loadOperands(8'hFF, 8'h01);
        applyStimulus("add_FF_01", 2'b00, 8'h00, 8'h00, 4'b0110, 2, 1, 1'b0);
        loadOperands(8'h80, 8'h01);
        applyStimulus("sub_80_01", 2'b01, 8'h7F, 8'h00, 4'b0011, 2, 1, 1'b0);

        loadOperands(8'h01, 8'h02);
        applyStimulus("acc_1", 2'b11, 8'h03, 8'h00, 4'b0000, 2, 1, 1'b0);
        applyStimulus("acc_2", 2'b11, 8'h05, 8'h00, 4'b0000, 2, 1, 1'b0);
        // A=05: accumulate with a LoadA and Start while busy -> single Done, A=07
        applyStimulus("acc_disturb", 2'b11, 8'h07, 8'h00, 4'b0000, 2, 1, 1'b1);
        // A must still be 07 (not AA), so A+B = 09
        applyStimulus("add_after_acc", 2'b00, 8'h09, 8'h00, 4'b0000, 2, 1, 1'b0);

`ifdef ARITH_MUL_EN
        loadOperands(8'h0F, 8'h11);
        applyStimulus("mul_0F_11", 2'b10, 8'hFF, 8'h00, 4'b0000, 10, 9, 1'b0);
        loadOperands(8'h10, 8'h10);
        applyStimulus("mul_10_10", 2'b10, 8'h00, 8'h01, 4'b0001, 10, 9, 1'b0);
        loadOperands(8'h0F, 8'h11);
        abortTest("abort_mul", 2'b10, 3);
`else
        loadOperands(8'h11, 8'h22);
        abortTest("abort_exec", 2'b00, 0);
`endif

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequential_arith_unit.md
SEQUENTIAL_ARITH_UNIT -- requirements
Module: sequential_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand and result width in bits (minimum 4).
REQ-002 SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Clear, input, 1 bit, the reset; synchronous and active-high.
REQ-004 SHALL have port X, input, WIDTH bits, the shared operand data bus.
REQ-005 SHALL have port LoadA, input, 1 bit, which loads X into operand register A.
REQ-006 SHALL have port LoadB, input, 1 bit, which loads X into operand register B.
REQ-007 SHALL have port Op, input, 2 bits, the operation select: 00 add, 01 subtract, 10 multiply, 11 accumulate.
REQ-008 SHALL have port Start, input, 1 bit, a one-cycle request that begins the operation selected by Op.
REQ-009 SHALL have port Result, output, WIDTH bits, the registered low result.
REQ-010 SHALL have port ResultHi, output, WIDTH bits, the registered upper product half (zero for non-multiply operations).
REQ-011 SHALL have port Flags, output, 4 bits, the registered flags {N,Z,C,V}, with N at bit 3 and V at bit 0.
REQ-012 SHALL have port Busy, output, 1 bit, high while in the EXEC or MUL state.
REQ-013 SHALL have port Done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, MUL and DONE.
REQ-015 SHALL apply LoadA and LoadB only in IDLE when Start=0; loads in any other state or cycle are ignored.
REQ-016 SHALL, when Start=1 in IDLE, latch Op and the current A and B, then move to EXEC (Op 00/01/11) or MUL (Op 10).
REQ-017 SHALL ignore Start outside IDLE.
REQ-018 SHALL, in EXEC, compute one ripple add or subtract and register Result, ResultHi=0 and Flags, then go to DONE.
REQ-019 SHALL, in MUL, perform unsigned shift-add, one partial product per cycle, for exactly WIDTH cycles, then register the 2*WIDTH product as {ResultHi,Result} and go to DONE.
REQ-020 SHALL assert Done for one cycle in DONE, then return to IDLE; Busy SHALL be 0 in DONE.
REQ-021 SHALL give these latencies, with Start sampled at edge 0: add/subtract/accumulate Done high after edge 2; multiply Done high after edge WIDTH+2.
REQ-022 SHALL form subtract as A + ~B + 1; C is the carry out of that sum (1 means no borrow).
REQ-023 SHALL set flags for add/subtract/accumulate as: N = Result MSB; Z = Result==0; C = carry out; V = two's-complement signed overflow.
REQ-024 SHALL set flags for multiply as: N = product bit 2*WIDTH-1; Z = product==0; C = 0; V = ResultHi!=0.
REQ-025 SHALL, for accumulate, compute A+B as for add and also write the sum into A in the same cycle as Result, with flags as for add.
REQ-026 SHALL hold Result, ResultHi and Flags from DONE until the next operation completes.
REQ-027 SHALL ignore operand-register loads during an operation, so the latched operands are not disturbed.

Reset
REQ-028 SHALL, on Clear=1 at a rising edge, set the state to IDLE and clear A, B, Result, ResultHi, Flags, Busy and Done to 0, with priority over all other inputs.
REQ-029 SHALL, on Clear during EXEC or MUL, abort the operation with no Done pulse; the aborted result is never written.

Configuration
REQ-030 SHALL provide macro ARITH_MUL_EN; when defined, it compiles in the MUL state and the shift-add datapath with behaviour per REQ-019/024.
REQ-031 SHALL, when ARITH_MUL_EN is undefined, treat Op=10 as illegal: EXEC path timing, Done pulse after edge 2, Result, ResultHi and Flags retain their prior values, and no multiplier logic is synthesised.

Verification (WIDTH=8)
REQ-032 SHALL cover: A=05, B=03, add -> Result=08, Flags=0000, Done high exactly after edge 2, Busy high for 1 cycle.
REQ-033 SHALL cover: A=03, B=05, subtract -> Result=FE, Flags=1000; then A=7F, B=01, add -> Result=80, Flags=1001; then A=FF, B=01, add -> Result=00, Flags=0110.
REQ-034 SHALL cover, with ARITH_MUL_EN: A=0F, B=11, multiply -> {ResultHi,Result}=00FF, Flags=0000, Done after edge 10; then A=10, B=10 -> 0100, Flags=0001.
REQ-035 SHALL cover: A=01, B=02, accumulate twice -> Result=03 then 05, A=05; a Start pulse and LoadA during Busy are ignored (A unchanged, a single Done).
REQ-036 SHALL cover: Clear asserted at MUL cycle 4 -> next cycle state IDLE, Busy=0, Result=00, Flags=0000, no Done pulse.
REQ-037 SHALL cover, without ARITH_MUL_EN: prior Result=08, Op=10, Start -> Done after edge 2, Result=08, Flags unchanged.
